median_sort_pipe: RTL and testbench

Parametrised, pipelined sorting network that sorts N unsigned or signed WIDTH-bit samples per transaction and also presents the median. Successor to the fixed 5-input, 32-bit combinational median network: it adds arbitrary N, a signed mode, one register per compare-exchange stage, and valid/ready flow control with backpressure. It sits between a sample-gathering front end and downstream filter logic, and sustains one vector per clock.

---
 rtl/median_sort_pipe.sv | 97 +++++++++
 tb/tb_median_sort_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_sort_pipe.sv
// median_sort_pipe
//   Pipelined odd-even transposition sorter for N samples of WIDTH bits.
//   Every compare-exchange stage is registered together with a valid bit.
//   One global advance signal moves the whole pipeline, so bubbles are
//   carried through rather than compressed. The output is the last stage
//   register, and the median is a fixed slice of it.
//
// Parameters
//   WIDTH   bits per sample
//   N       samples per vector (2..16)
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears all data and valid bits
//   in_valid   data_in carries a vector
//   in_ready   vector accepted this cycle if in_valid (= advance)
//   data_in    sample i at [i*WIDTH +: WIDTH]
//   out_valid  sort_out / median valid
//   out_ready  consumer takes the output this cycle
//   sort_out   ascending, smallest at [0 +: WIDTH]
//   median     sorted element (N-1)/2 (lower median for even N)
//   busy       some stage holds a valid vector
module median_sort_pipe #(
  parameter int WIDTH  = 32,
  parameter int N      = 5,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   sort_out,
  output logic [WIDTH-1:0]     median,
  output logic                 busy
);

  logic [N*WIDTH-1:0] r_data [N];
  logic [N-1:0]       r_vld;

  logic [N*WIDTH-1:0] w_stage_in  [N];
  logic [N*WIDTH-1:0] w_stage_out [N];
  logic               w_advance;

  // True when a must move above b. Equal values never swap.
  function automatic logic f_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) f_gt = ($signed(a) > $signed(b));
    else             f_gt = (a > b);
  endfunction

  always_comb begin
    w_stage_in[0] = data_in;
    for (int unsigned s = 1; s < N; s++) begin
      w_stage_in[s] = r_data[s-1];
    end
  end

  // Stage s pairs (s%2, s%2+1), (s%2+2, s%2+3), ... ; an unpaired top
  // element simply passes through via the default copy.
  always_comb begin
    for (int unsigned s = 0; s < N; s++) begin
      w_stage_out[s] = w_stage_in[s];
      for (int unsigned i = s % 2; i + 1 < N; i += 2) begin
        if (f_gt(w_stage_in[s][i*WIDTH +: WIDTH], w_stage_in[s][(i+1)*WIDTH +: WIDTH])) begin
          w_stage_out[s][i*WIDTH +: WIDTH]     = w_stage_in[s][(i+1)*WIDTH +: WIDTH];
          w_stage_out[s][(i+1)*WIDTH +: WIDTH] = w_stage_in[s][i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign w_advance = !r_vld[N-1] || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < N; s++) begin
        r_data[s] <= '0;
      end
      r_vld <= '0;
    end else if (w_advance) begin
      for (int unsigned s = 0; s < N; s++) begin
        r_data[s] <= w_stage_out[s];
      end
      r_vld <= {r_vld[N-2:0], in_valid};
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = r_vld[N-1];
  assign sort_out  = r_data[N-1];
  assign median    = r_data[N-1][((N-1)/2)*WIDTH +: WIDTH];
  assign busy      = |r_vld;

endmodule

// File: tb/tb_median_sort_pipe.sv
// Bench for median_sort_pipe: three instances (N=5 unsigned, N=4 signed,
// N=2 unsigned). Stimulus pushes expected sorted vectors into per-instance
// queues; independent monitors pop and compare on every output transfer.
module tb_median_sort_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic a_iv = 1'b0, a_ir, a_ov, a_or = 1'b1, a_busy;
  logic [5*W-1:0] a_din = '0, a_sort;
  logic [W-1:0]   a_med;
  logic b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1, b_busy;
  logic [4*W-1:0] b_din = '0, b_sort;
  logic [W-1:0]   b_med;
  logic c_iv = 1'b0, c_ir, c_ov, c_or = 1'b1, c_busy;
  logic [2*W-1:0] c_din = '0, c_sort;
  logic [W-1:0]   c_med;

  median_sort_pipe #(.WIDTH(W), .N(5), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .data_in(a_din),
    .out_valid(a_ov), .out_ready(a_or), .sort_out(a_sort), .median(a_med), .busy(a_busy));
  median_sort_pipe #(.WIDTH(W), .N(4), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .data_in(b_din),
    .out_valid(b_ov), .out_ready(b_or), .sort_out(b_sort), .median(b_med), .busy(b_busy));
  median_sort_pipe #(.WIDTH(W), .N(2), .SIGNED(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .data_in(c_din),
    .out_valid(c_ov), .out_ready(c_or), .sort_out(c_sort), .median(c_med), .busy(c_busy));

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned a_run  = 0;
  int unsigned a_max  = 0;

  logic [5*W-1:0] qa [$];
  logic [4*W-1:0] qb [$];
  logic [2*W-1:0] qc [$];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred, none expected", nm);
  endtask

  // Monitors: sample mid-cycle, pop on each output transfer.
  always @(negedge clk) begin
    logic [5*W-1:0] e;
    if (a_ov) a_run++; else a_run = 0;
    if (a_run > a_max) a_max = a_run;
    if (!rst && a_ov && a_or) begin
      if (qa.size() == 0) flag("a_unexpected_output");
      else begin
        e = qa.pop_front();
        chk("a_sort", a_sort, e);
        chk("a_median", a_med, e[2*W +: W]);
      end
    end
  end

  always @(negedge clk) begin
    logic [4*W-1:0] e;
    if (!rst && b_ov && b_or) begin
      if (qb.size() == 0) flag("b_unexpected_output");
      else begin
        e = qb.pop_front();
        chk("b_sort", b_sort, e);
        chk("b_median", b_med, e[1*W +: W]);
      end
    end
  end

  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (!rst && c_ov && c_or) begin
      if (qc.size() == 0) flag("c_unexpected_output");
      else begin
        e = qc.pop_front();
        chk("c_sort", c_sort, e);
        chk("c_median", c_med, e[0 +: W]);
      end
    end
  end

  function automatic logic ov_of(input int d);
    case (d)
      0:       return a_ov;
      1:       return b_ov;
      default: return c_ov;
    endcase
  endfunction

  function automatic logic ir_of(input int d);
    case (d)
      0:       return a_ir;
      1:       return b_ir;
      default: return c_ir;
    endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic [159:0] din);
    case (d)
      0:       begin a_iv = v; a_din = din;          end
      1:       begin b_iv = v; b_din = din[127:0];   end
      default: begin c_iv = v; c_din = din[63:0];    end
    endcase
  endtask

  task automatic push(input int d, input logic [159:0] e);
    case (d)
      0:       qa.push_back(e);
      1:       qb.push_back(e[127:0]);
      default: qc.push_back(e[63:0]);
    endcase
  endtask

  // Present a vector until accepted (bounded); called at posedge+1.
  task automatic send(input int d, input logic [159:0] din, input logic [159:0] e,
                      input bit do_push);
    bit acc;
    acc = 1'b0;
    drive(d, 1'b1, din);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = ir_of(d);
      @(posedge clk);
      #1;
    end
    if (!acc) flag("send_timeout");
    else if (do_push) push(d, e);
    drive(d, 1'b0, din);
  endtask

  // Isolated vector into an idle pipeline: out_valid must first appear
  // n edges after the cycle it was presented, for exactly one cycle.
  task automatic lat(input int d, input int n, input logic [159:0] din, input logic [159:0] e);
    int cnt;
    push(d, e);
    drive(d, 1'b1, din);
    @(posedge clk);
    #1;
    drive(d, 1'b0, din);
    cnt = 1;
    while (!ov_of(d) && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("latency", cnt, n);
    @(posedge clk);
    #1;
    chk("single_pulse", ov_of(d), 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0 ||
            a_busy || b_busy || c_busy) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 300) flag("drain_timeout");
  endtask

  task automatic wait_ov_a();
    int k;
    k = 0;
    @(negedge clk);
    while (!a_ov && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) flag("a_out_valid_timeout");
  endtask

  function automatic logic [159:0] ref_sort5(input logic [159:0] v);
    logic [31:0] a [5];
    logic [31:0] t;
    int j;
    for (int i = 0; i < 5; i++) a[i] = v[i*32 +: 32];
    for (int i = 1; i < 5; i++) begin
      t = a[i];
      j = i - 1;
      while (j >= 0 && a[j] > t) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = t;
    end
    for (int i = 0; i < 5; i++) ref_sort5[i*32 +: 32] = a[i];
  endfunction

  initial begin
    logic [159:0] v;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", a_ov, 1'b0);
    chk("rst_sort_out",  a_sort, '0);
    chk("rst_median",    a_med, '0);
    chk("rst_busy",      a_busy, 1'b0);
    chk("rst_in_ready",  a_ir, 1'b1);
    chk("rst_b_out_valid", b_ov, 1'b0);
    chk("rst_c_out_valid", c_ov, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single vector {3,2,4,1,5} (elements 4..0), 5-cycle latency.
    lat(0, 5, {32'd3, 32'd2, 32'd4, 32'd1, 32'd5}, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    chk("idle_busy", a_busy, 1'b0);

    // Directed vectors back-to-back.
    send(0, {32'd7, 32'd7, 32'd7, 32'd7, 32'd7}, {32'd7, 32'd7, 32'd7, 32'd7, 32'd7}, 1);
    send(0, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5}, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 1);
    send(0, {32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h7FFFFFFF},
            {32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h0}, 1);
    send(0, {32'd9, 32'd0, 32'd9, 32'd0, 32'd5}, {32'd9, 32'd9, 32'd5, 32'd0, 32'd0}, 1);
    #1 chk("busy_in_flight", a_busy, 1'b1);
    drain();

    // Signed N=4.
    send(1, {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000000},
            {32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h80000000}, 1);
    send(1, {32'd5, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd1},
            {32'd5, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFD}, 1);
    drain();

    // N=2 extremes, both orders.
    lat(2, 2, {32'h0, 32'hFFFFFFFF}, {32'hFFFFFFFF, 32'h0});
    send(2, {32'hFFFFFFFF, 32'h0}, {32'hFFFFFFFF, 32'h0}, 1);
    drain();

    // Streaming: 100 vectors back-to-back, mixing wide values and duplicates.
    a_max = 0;
    for (int n = 0; n < 100; n++) begin
      for (int j = 0; j < 5; j++) v[j*32 +: 32] = (j % 2 == 0) ? $urandom : $urandom_range(0, 3);
      send(0, v, ref_sort5(v), 1);
    end
    drain();
    chk("stream_consecutive", a_max, 100);

    // Backpressure: 4-cycle stall, input offered during stall, released
    // together with the accept.
    a_or = 1'b0;
    send(0, {32'd50, 32'd40, 32'd30, 32'd20, 32'd10}, {32'd50, 32'd40, 32'd30, 32'd20, 32'd10}, 1);
    send(0, {32'd1, 32'd1, 32'd2, 32'd2, 32'd0}, {32'd2, 32'd2, 32'd1, 32'd1, 32'd0}, 1);
    send(0, {32'd8, 32'd6, 32'd4, 32'd2, 32'd9}, {32'd9, 32'd8, 32'd6, 32'd4, 32'd2}, 1);
    wait_ov_a();
    a_iv  = 1'b1;
    a_din = {32'd100, 32'd300, 32'd200, 32'd500, 32'd400};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_out_valid", a_ov, 1'b1);
      chk("stall_sort_out",  a_sort, qa[0]);
      chk("stall_median",    a_med, qa[0][2*W +: W]);
      chk("stall_in_ready",  a_ir, 1'b0);
    end
    @(posedge clk);
    #1 a_or = 1'b1;
    #1 chk("release_in_ready", a_ir, 1'b1);
    send(0, {32'd100, 32'd300, 32'd200, 32'd500, 32'd400},
            {32'd500, 32'd400, 32'd300, 32'd200, 32'd100}, 1);
    drain();

    // Reset mid-stream with 3 vectors in flight: none may be emitted.
    a_or = 1'b0;
    send(0, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5}, '0, 0);
    send(0, {32'd6, 32'd7, 32'd8, 32'd9, 32'd10}, '0, 0);
    send(0, {32'd11, 32'd12, 32'd13, 32'd14, 32'd15}, '0, 0);
    wait_ov_a();
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", a_ov, 1'b0);
    chk("midrst_sort_out",  a_sort, '0);
    chk("midrst_median",    a_med, '0);
    chk("midrst_busy",      a_busy, 1'b0);
    chk("midrst_in_ready",  a_ir, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    a_or = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    lat(0, 5, {32'd4, 32'd4, 32'd0, 32'd3, 32'd1}, {32'd4, 32'd4, 32'd3, 32'd1, 32'd0});
    drain();

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
